// File: rtl/fault_campaign_injector.sv
// Streaming fault injector: registers a valid-qualified beat and XORs a configurable fault mask
// into selected beats (single/adjacent/double/burst, fixed or LFSR position, periodic, bounded).
module fault_campaign_injector #(
  parameter int          WIDTH     = 32,
  parameter int          PERIOD_W  = 16,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         POS_W     = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_stop,
  input  logic [1:0]          cfg_mode,
  input  logic [POS_W-1:0]    cfg_pos,
  input  logic [POS_W-1:0]    cfg_pos2,
  input  logic                cfg_rand,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [CNT_W-1:0]    cfg_count,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    in_data,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_inj,
  output logic [WIDTH-1:0]    out_mask,
  output logic                busy,
  output logic [CNT_W-1:0]    inj_count
);

  // state   | meaning
  // S_IDLE  | pass-through, waiting for cfg_start
  // S_ARMED | counting valid beats and injecting on period hits
  // S_DONE  | injection budget used up, pass-through
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic                out_inj_q, out_inj_d;
  logic [WIDTH-1:0]    out_mask_q, out_mask_d;
  logic [CNT_W-1:0]    inj_count_q, inj_count_d;
  logic [PERIOD_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [1:0]          mode_q, mode_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [POS_W-1:0]    pos2_q, pos2_d;
  logic                rnd_q, rnd_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [PERIOD_W-1:0] period_eff;
  logic [POS_W-1:0]    base_pos;
  int unsigned         pb;
  logic [WIDTH-1:0]    mask_sel;
  logic [WIDTH-1:0]    mask;
  logic                beat_ok;
  logic                hit;
  logic                fire;
  logic [CNT_W-1:0]    inj_next;

  function automatic logic [WIDTH-1:0] onehot(input int unsigned p);
    return WIDTH'(1) << (p % WIDTH);
  endfunction

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    lfsr_d      = lfsr_q;
    inj_count_d = inj_count_q;
    mode_d      = mode_q;
    pos_d       = pos_q;
    pos2_d      = pos2_q;
    rnd_d       = rnd_q;
    period_d    = period_q;
    count_d     = count_q;
    inj_next    = inj_count_q;

    period_eff = (period_q == '0) ? PERIOD_W'(1) : period_q;
    base_pos   = rnd_q ? POS_W'(lfsr_q % 16'(WIDTH)) : pos_q;
    pb         = 32'(base_pos);

    case (mode_q)
      2'd0:    mask_sel = onehot(pb);
      2'd1:    mask_sel = onehot(pb) | onehot(pb + 1);
      2'd2:    mask_sel = onehot(pb) | onehot(32'(pos2_q));
      default: mask_sel = onehot(pb) | onehot(pb + 1) | onehot(pb + 2) | onehot(pb + 3);
    endcase

    // A beat arriving alongside a start/stop belongs to the old campaign's teardown, not to it.
    beat_ok = (state_q == S_ARMED) && in_valid && !cfg_start && !cfg_stop;
    hit     = (beat_cnt_q == period_eff - PERIOD_W'(1));
    fire    = beat_ok && hit;
    mask    = fire ? mask_sel : '0;

    out_valid_d = in_valid;
    out_data_d  = in_data ^ mask;
    out_inj_d   = fire;
    out_mask_d  = mask;

    if (beat_ok) beat_cnt_d = hit ? '0 : beat_cnt_q + PERIOD_W'(1);

    if (fire) begin
      lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      inj_next    = (&inj_count_q) ? inj_count_q : inj_count_q + CNT_W'(1);
      inj_count_d = inj_next;
      if (count_q != '0 && inj_next == count_q) state_d = S_DONE;
    end

    if (cfg_stop) begin
      state_d    = S_IDLE;
      beat_cnt_d = '0;
    end else if (cfg_start) begin
      state_d     = S_ARMED;
      beat_cnt_d  = '0;
      inj_count_d = '0;
      lfsr_d      = LFSR_SEED;
      mode_d      = cfg_mode;
      pos_d       = cfg_pos;
      pos2_d      = cfg_pos2;
      rnd_d       = cfg_rand;
      period_d    = cfg_period;
      count_d     = cfg_count;
    end

    busy_d = (state_d == S_ARMED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_inj_q   <= 1'b0;
      out_mask_q  <= '0;
      inj_count_q <= '0;
      beat_cnt_q  <= '0;
      lfsr_q      <= LFSR_SEED;
      mode_q      <= '0;
      pos_q       <= '0;
      pos2_q      <= '0;
      rnd_q       <= 1'b0;
      period_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_inj_q   <= out_inj_d;
      out_mask_q  <= out_mask_d;
      inj_count_q <= inj_count_d;
      beat_cnt_q  <= beat_cnt_d;
      lfsr_q      <= lfsr_d;
      mode_q      <= mode_d;
      pos_q       <= pos_d;
      pos2_q      <= pos2_d;
      rnd_q       <= rnd_d;
      period_q    <= period_d;
      count_q     <= count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_inj   = out_inj_q;
  assign out_mask  = out_mask_q;
  assign busy      = busy_q;
  assign inj_count = inj_count_q;

endmodule

// File: tb/tb_fault_campaign_injector.sv
// Directed bench for fault_campaign_injector: hand-computed masks, periodic/bounded campaigns,
// LFSR reseed repeatability, async reset and start/stop collision.
module tb_fault_campaign_injector;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start, cfg_stop, cfg_rand;
  logic [1:0]  cfg_mode;
  logic [4:0]  cfg_pos, cfg_pos2;
  logic [15:0] cfg_period, cfg_count;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_valid, out_inj, busy;
  logic [31:0] out_data, out_mask;
  logic [15:0] inj_count;

  int n_cmp = 0;
  int n_err = 0;

  fault_campaign_injector dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_mode(cfg_mode),
    .cfg_pos(cfg_pos), .cfg_pos2(cfg_pos2), .cfg_rand(cfg_rand),
    .cfg_period(cfg_period), .cfg_count(cfg_count),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_inj(out_inj),
    .out_mask(out_mask), .busy(busy), .inj_count(inj_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic start_cfg(input logic [1:0] m, input logic [4:0] p, input logic [4:0] p2,
                           input logic r, input logic [15:0] per, input logic [15:0] cnt);
    cfg_mode = m; cfg_pos = p; cfg_pos2 = p2; cfg_rand = r; cfg_period = per; cfg_count = cnt;
    cfg_start = 1'b1;
    step(1'b0, 32'h0);
    cfg_start = 1'b0;
  endtask

  task automatic stop_cfg();
    cfg_stop = 1'b1;
    step(1'b0, 32'h0);
    cfg_stop = 1'b0;
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  logic [31:0] run1 [6];
  logic [15:0] ml;
  logic [31:0] em;

  initial begin
    rst = 1'b1; cfg_start = 0; cfg_stop = 0; cfg_rand = 0; cfg_mode = 0;
    cfg_pos = 0; cfg_pos2 = 0; cfg_period = 0; cfg_count = 0; in_valid = 0; in_data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_inj_count", inj_count, 0);
    rst = 1'b0;
    step(1'b1, 32'h1234);
    chk("idle_pass", out_data, 32'h1234);
    chk("idle_no_inj", out_inj, 0);

    // single bit, every beat; cfg changes while armed must be ignored
    start_cfg(2'd0, 5'd5, 5'd0, 1'b0, 16'd1, 16'd0);
    chk("t1_busy", busy, 1);
    cfg_pos = 5'd9; cfg_mode = 2'd3;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h0);
      chk("t1_data", out_data, 32'h20);
      chk("t1_inj", out_inj, 1);
    end
    step(1'b1, 32'hFFFF_FFFF);
    chk("t1_data_ones", out_data, 32'hFFFF_FFDF);
    step(1'b0, 32'h0);
    chk("t1_gap_valid", out_valid, 0);
    chk("t1_gap_inj", out_inj, 0);
    chk("t1_gap_mask", out_mask, 0);
    chk("t1_count", inj_count, 5);

    // wrap-around adjacent and burst
    start_cfg(2'd1, 5'd31, 5'd0, 1'b0, 16'd1, 16'd0);
    step(1'b1, 32'h0);
    chk("t2_adj_wrap", out_mask, 32'h8000_0001);
    chk("t2_adj_data", out_data, 32'h8000_0001);
    start_cfg(2'd3, 5'd30, 5'd0, 1'b0, 16'd1, 16'd0);
    step(1'b1, 32'h0);
    chk("t2_burst_wrap", out_mask, 32'hC000_0003);
    start_cfg(2'd3, 5'd4, 5'd0, 1'b0, 16'd1, 16'd0);
    step(1'b1, 32'hFFFF_FFFF);
    chk("t2_burst_mid", out_data, 32'hFFFF_FF0F);

    // two explicit positions
    start_cfg(2'd2, 5'd3, 5'd3, 1'b0, 16'd1, 16'd0);
    step(1'b1, 32'h0);
    chk("t3_same_pos", out_mask, 32'h8);
    start_cfg(2'd2, 5'd3, 5'd10, 1'b0, 16'd1, 16'd0);
    step(1'b1, 32'h0);
    chk("t3_two_pos", out_mask, 32'h408);

    // period 0 behaves as 1
    start_cfg(2'd0, 5'd2, 5'd0, 1'b0, 16'd0, 16'd0);
    step(1'b1, 32'h0);
    step(1'b1, 32'h0);
    chk("t3_period0", out_mask, 32'h4);

    // period 3, budget 2, gaps between beats
    start_cfg(2'd0, 5'd0, 5'd0, 1'b0, 16'd3, 16'd2);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 32'h100 + k);
      chk("t4_inj", out_inj, (k == 3 || k == 6));
      chk("t4_data", out_data, (k == 3 || k == 6) ? (32'h100 + k) ^ 32'h1 : 32'h100 + k);
      chk("t4_busy", busy, (k < 6));
      if (k % 2 == 1) step(1'b0, 32'h0);
    end
    chk("t4_count", inj_count, 2);

    // budget of one at period 1
    start_cfg(2'd0, 5'd7, 5'd0, 1'b0, 16'd1, 16'd1);
    step(1'b1, 32'h0);
    chk("t4_cnt1_inj", out_mask, 32'h80);
    chk("t4_cnt1_busy", busy, 0);
    step(1'b1, 32'h0);
    chk("t4_cnt1_after", out_inj, 0);

    // random position, repeatable after restart
    start_cfg(2'd0, 5'd0, 5'd0, 1'b1, 16'd1, 16'd0);
    ml = 16'hACE1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'h0);
      em = 32'h1 << ml[4:0];
      run1[i] = out_mask;
      chk("t5_run1", out_mask, em);
      ml = lfsr_adv(ml);
    end
    start_cfg(2'd0, 5'd0, 5'd0, 1'b1, 16'd1, 16'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'h0);
      chk("t5_run2", out_mask, run1[i]);
    end

    // stop mid-campaign
    start_cfg(2'd0, 5'd1, 5'd0, 1'b0, 16'd1, 16'd0);
    stop_cfg();
    chk("t6_stop_busy", busy, 0);
    step(1'b1, 32'h0);
    chk("t6_stop_pass", out_data, 32'h0);

    // async reset between edges
    start_cfg(2'd0, 5'd1, 5'd0, 1'b0, 16'd1, 16'd0);
    step(1'b1, 32'h0);
    chk("t6_pre_rst", out_data, 32'h2);
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_data", out_data, 0);
    chk("t6_rst_inj", out_inj, 0);
    chk("t6_rst_mask", out_mask, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_cnt", inj_count, 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 32'h0);
    chk("t6_post_rst_idle", out_inj, 0);

    // start and stop together: stop wins
    cfg_start = 1'b1; cfg_stop = 1'b1;
    step(1'b0, 32'h0);
    cfg_start = 1'b0; cfg_stop = 1'b0;
    chk("t6_both_busy", busy, 0);
    step(1'b1, 32'h55);
    chk("t6_both_data", out_data, 32'h55);
    chk("t6_both_inj", out_inj, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
